// File: rtl/autocorr_pkg.sv
// Shared types for the auto-correlation lag sweep controller.
// State encoding and default result-record field widths.
package autocorr_pkg;

  localparam int DELTA_W = 8;
  localparam int OUT_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_PUSH = 2'd3
  } state_e;

endpackage

// File: rtl/auto_correlation_sweep_ctrl_if.sv
// Result-record valid/ready channel of the lag sweep controller.
// master = controller (producer), slave = consumer.
interface auto_correlation_sweep_ctrl_if
  import autocorr_pkg::*;
#(
  parameter int DELTA_WIDTH = DELTA_W,
  parameter int OUT_WIDTH   = OUT_W
);

  logic                   o_res_valid;
  logic                   i_res_ready;
  logic [DELTA_WIDTH-1:0] o_res_delta;
  logic [OUT_WIDTH-1:0]   o_res_total;
  logic [OUT_WIDTH-1:0]   o_res_match;
  logic                   o_res_sat;

  modport master (
    output o_res_valid,
    input  i_res_ready,
    output o_res_delta,
    output o_res_total,
    output o_res_match,
    output o_res_sat
  );

  modport slave (
    input  o_res_valid,
    output i_res_ready,
    input  o_res_delta,
    input  o_res_total,
    input  o_res_match,
    input  o_res_sat
  );

endinterface

// File: rtl/autocorr_bound_check.sv
// Sticky out-of-window alarm on accepted match counts.
// Only instantiated when AUTOCORR_ALARM_EN is defined.
module autocorr_bound_check #(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 chk_i,
  input  logic [OUT_WIDTH-1:0] match_i,
  input  logic [OUT_WIDTH-1:0] lo_i,
  input  logic [OUT_WIDTH-1:0] hi_i,
  output logic                 alarm_o
);

  logic alarm_q, alarm_d;
  logic out_of_win;

  assign out_of_win = (match_i < lo_i) | (match_i > hi_i);

  always_comb begin
    alarm_d = alarm_q;
    if (clr_i)
      alarm_d = 1'b0;
    else if (chk_i && out_of_win)
      alarm_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) alarm_q <= 1'b0;
    else         alarm_q <= alarm_d;
  end

  assign alarm_o = alarm_q;

endmodule

// File: rtl/auto_correlation_sweep_ctrl.sv
// Steps one auto_correlation datapath over a lag range, one record per lag.
// Optional sticky match-window alarm: define AUTOCORR_ALARM_EN.
module auto_correlation_sweep_ctrl
  import autocorr_pkg::*;
#(
  parameter int DELTA_WIDTH = DELTA_W,
  parameter int OUT_WIDTH   = OUT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [DELTA_WIDTH-1:0] i_delta_first,
  input  logic [DELTA_WIDTH-1:0] i_delta_last,
  input  logic [OUT_WIDTH-1:0]   i_nsamples,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_ac_init,
  output logic [DELTA_WIDTH-1:0] o_ac_delta,
  input  logic [OUT_WIDTH-1:0]   i_ac_write_cnt,
  input  logic [OUT_WIDTH-1:0]   i_ac_match_cnt,
  input  logic                   i_ac_full,
`ifdef AUTOCORR_ALARM_EN
  input  logic [OUT_WIDTH-1:0]   i_lo_bound,
  input  logic [OUT_WIDTH-1:0]   i_hi_bound,
  output logic                   o_alarm,
`endif
  auto_correlation_sweep_ctrl_if.master res
);

  localparam logic [DELTA_WIDTH-1:0] ONE =
    {{(DELTA_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [DELTA_WIDTH-1:0] cur_q, cur_d;
  logic [DELTA_WIDTH-1:0] last_q, last_d;
  logic [OUT_WIDTH-1:0]   nsamp_q, nsamp_d;
  logic [DELTA_WIDTH-1:0] rdelta_q, rdelta_d;
  logic [OUT_WIDTH-1:0]   rtotal_q, rtotal_d;
  logic [OUT_WIDTH-1:0]   rmatch_q, rmatch_d;
  logic                   rsat_q, rsat_d;
  logic                   init_q, init_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   hs;
  logic                   hit;
  logic                   short_cnt;

  assign short_cnt = i_ac_write_cnt < nsamp_q;
  assign hit       = ~short_cnt | i_ac_full;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    nsamp_d  = nsamp_q;
    rdelta_d = rdelta_q;
    rtotal_d = rtotal_q;
    rmatch_d = rmatch_q;
    rsat_d   = rsat_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    hs       = 1'b0;
    // Abort overrides everything, including a same-cycle start.
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            accept  = 1'b1;
            cur_d   = i_delta_first;
            last_d  = i_delta_last;
            nsamp_d = i_nsamples;
            state_d = ST_INIT;
          end
        end
        ST_INIT: state_d = ST_RUN;
        ST_RUN: begin
          if (hit) begin
            rdelta_d = cur_q;
            rtotal_d = i_ac_write_cnt;
            rmatch_d = i_ac_match_cnt;
            rsat_d   = i_ac_full & short_cnt;
            state_d  = ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (res.i_res_ready) begin
            hs = 1'b1;
            if (cur_q == last_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cur_d   = cur_q + ONE;
              state_d = ST_INIT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    init_d = state_d == ST_INIT;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      nsamp_q  <= '0;
      rdelta_q <= '0;
      rtotal_q <= '0;
      rmatch_q <= '0;
      rsat_q   <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      nsamp_q  <= nsamp_d;
      rdelta_q <= rdelta_d;
      rtotal_q <= rtotal_d;
      rmatch_q <= rmatch_d;
      rsat_q   <= rsat_d;
      init_q   <= init_d;
      done_q   <= done_d;
    end
  end

  assign o_busy      = state_q != ST_IDLE;
  assign o_done      = done_q;
  assign o_ac_init   = init_q;
  assign o_ac_delta  = cur_q;

  assign res.o_res_valid = state_q == ST_PUSH;
  assign res.o_res_delta = rdelta_q;
  assign res.o_res_total = rtotal_q;
  assign res.o_res_match = rmatch_q;
  assign res.o_res_sat   = rsat_q;

`ifdef AUTOCORR_ALARM_EN
  autocorr_bound_check #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_bound (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clr_i   (accept),
    .chk_i   (hs),
    .match_i (rmatch_q),
    .lo_i    (i_lo_bound),
    .hi_i    (i_hi_bound),
    .alarm_o (o_alarm)
  );
`endif

endmodule

// File: tb/tb_auto_correlation_sweep_ctrl.sv
// Directed bench for the lag sweep controller with a counting datapath model.
// Alarm checks are compiled in when AUTOCORR_ALARM_EN is defined.
module tb_auto_correlation_sweep_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [7:0]  i_delta_first;
  logic [7:0]  i_delta_last;
  logic [31:0] i_nsamples;
  logic        o_busy;
  logic        o_done;
  logic        o_ac_init;
  logic [7:0]  o_ac_delta;
  logic [31:0] i_ac_write_cnt;
  logic [31:0] i_ac_match_cnt;
  logic        i_ac_full;
  logic [31:0] i_lo_bound;
  logic [31:0] i_hi_bound;
  logic        o_alarm;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wcnt;
  logic [31:0] full_lim;
  logic [31:0] match_val;

  logic [7:0]  rd[$];
  logic [31:0] rt[$];
  logic [31:0] rm[$];
  logic        rs[$];
  int          ndone;

  auto_correlation_sweep_ctrl_if #(
    .DELTA_WIDTH (8),
    .OUT_WIDTH   (32)
  ) res ();

  auto_correlation_sweep_ctrl #(
    .DELTA_WIDTH (8),
    .OUT_WIDTH   (32)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_delta_first  (i_delta_first),
    .i_delta_last   (i_delta_last),
    .i_nsamples     (i_nsamples),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_ac_init      (o_ac_init),
    .o_ac_delta     (o_ac_delta),
    .i_ac_write_cnt (i_ac_write_cnt),
    .i_ac_match_cnt (i_ac_match_cnt),
    .i_ac_full      (i_ac_full),
`ifdef AUTOCORR_ALARM_EN
    .i_lo_bound     (i_lo_bound),
    .i_hi_bound     (i_hi_bound),
    .o_alarm        (o_alarm),
`endif
    .res            (res)
  );

`ifndef AUTOCORR_ALARM_EN
  assign o_alarm = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  // Datapath model: counters clear on init, then count one sample per cycle.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      wcnt <= '0;
    else if (o_ac_init)
      wcnt <= '0;
    else if (full_lim == 0 || wcnt < full_lim)
      wcnt <= wcnt + 1;
  end

  assign i_ac_write_cnt = wcnt;
  assign i_ac_match_cnt = match_val;
  assign i_ac_full = (full_lim != 0) && (wcnt >= full_lim);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic sweep(input logic [7:0] f,
                       input logic [7:0] l,
                       input logic [31:0] n,
                       input int nrec,
                       input int budget);
    bit hs_prev;
    bit last_prev;
    bit fin;
    rd.delete();
    rt.delete();
    rm.delete();
    rs.delete();
    ndone = 0;
    i_delta_first = f;
    i_delta_last = l;
    i_nsamples = n;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    hs_prev = 0;
    last_prev = 0;
    fin = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      if (hs_prev)
        check("hs2init", {63'd0, o_ac_init}, {63'd0, !last_prev});
      if (o_done) begin
        ndone++;
        fin = 1;
      end
      hs_prev = res.o_res_valid && res.i_res_ready;
      if (hs_prev) begin
        rd.push_back(res.o_res_delta);
        rt.push_back(res.o_res_total);
        rm.push_back(res.o_res_match);
        rs.push_back(res.o_res_sat);
        last_prev = rd.size() == nrec;
      end
      if (!fin) step();
    end
    if (!fin) check("sweep_timeout", 64'd0, 64'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_done) ndone++;
    end
  endtask

  initial begin
    int bad;
    int ninit;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_delta_first = '0;
    i_delta_last = '0;
    i_nsamples = '0;
    i_lo_bound = 32'd40;
    i_hi_bound = 32'd60;
    full_lim = '0;
    match_val = 32'h1234;
    res.i_res_ready = 1'b1;
    step();
    step();
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_init", {63'd0, o_ac_init}, 64'd0);
    check("rst_valid", {63'd0, res.o_res_valid}, 64'd0);
    check("rst_rtotal", {32'd0, res.o_res_total}, 64'd0);
    check("rst_acdelta", {56'd0, o_ac_delta}, 64'd0);
    check("rst_alarm", {63'd0, o_alarm}, 64'd0);
    i_rst_n = 1'b1;
    step();

    // Plain three-lag sweep
    sweep(8'd3, 8'd5, 32'd100, 3, 1000);
    check("t1_nrec", rd.size(), 64'd3);
    for (int i = 0; i < 3 && i < rd.size(); i++) begin
      check("t1_delta", {56'd0, rd[i]}, 64'd3 + i);
      check("t1_total", {32'd0, rt[i]}, 64'd100);
      check("t1_match", {32'd0, rm[i]}, 64'h1234);
      check("t1_sat", {63'd0, rs[i]}, 64'd0);
    end
    check("t1_done", ndone, 64'd1);
    check("t1_busy", {63'd0, o_busy}, 64'd0);

    // Wrap through 255 -> 0
    sweep(8'd255, 8'd1, 32'd5, 3, 200);
    check("t2_nrec", rd.size(), 64'd3);
    if (rd.size() == 3) begin
      check("t2_d0", {56'd0, rd[0]}, 64'd255);
      check("t2_d1", {56'd0, rd[1]}, 64'd0);
      check("t2_d2", {56'd0, rd[2]}, 64'd1);
      check("t2_total", {32'd0, rt[2]}, 64'd5);
    end
    check("t2_done", ndone, 64'd1);

    // Backpressure: record must hold while ready is low
    res.i_res_ready = 1'b0;
    i_delta_first = 8'd10;
    i_delta_last = 8'd10;
    i_nsamples = 32'd4;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    bad = 0;
    for (int c = 0; c < 50 && !res.o_res_valid; c++) step();
    check("t3_valid", {63'd0, res.o_res_valid}, 64'd1);
    for (int c = 0; c < 20; c++) begin
      if (!res.o_res_valid || res.o_res_delta != 8'd10 ||
          res.o_res_total != 32'd4 || res.o_res_match != 32'h1234 ||
          res.o_res_sat || o_ac_init || o_done)
        bad++;
      step();
    end
    check("t3_hold_bad", bad, 64'd0);
    res.i_res_ready = 1'b1;
    step();
    check("t3_done", {63'd0, o_done}, 64'd1);
    check("t3_busy", {63'd0, o_busy}, 64'd0);
    check("t3_valid_off", {63'd0, res.o_res_valid}, 64'd0);
    step();

    // Abort during RUN of the second lag
    i_delta_first = 8'd20;
    i_delta_last = 8'd25;
    i_nsamples = 32'd30;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    ninit = 0;
    for (int c = 0; c < 200 && ninit < 2; c++) begin
      if (o_ac_init) ninit++;
      if (ninit < 2) step();
    end
    check("t4_init2", ninit, 64'd2);
    check("t4_delta2", {56'd0, o_ac_delta}, 64'd21);
    step();
    step();
    step();
    check("t4_busy_run", {63'd0, o_busy}, 64'd1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("t4_busy_abort", {63'd0, o_busy}, 64'd0);
    check("t4_valid_abort", {63'd0, res.o_res_valid}, 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (res.o_res_valid || o_done || o_ac_init || o_busy) bad++;
      step();
    end
    check("t4_quiet", bad, 64'd0);

    // Start and abort together in IDLE: abort wins
    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    check("sa_busy", {63'd0, o_busy}, 64'd0);
    check("sa_init", {63'd0, o_ac_init}, 64'd0);

    // Saturated datapath
    full_lim = 32'd50;
    sweep(8'd7, 8'd7, 32'd100, 1, 300);
    full_lim = 32'd0;
    check("t5_nrec", rd.size(), 64'd1);
    if (rd.size() == 1) begin
      check("t5_delta", {56'd0, rd[0]}, 64'd7);
      check("t5_total", {32'd0, rt[0]}, 64'd50);
      check("t5_sat", {63'd0, rs[0]}, 64'd1);
    end

    // Zero samples -> immediate capture; out-of-window match
    match_val = 32'd70;
    sweep(8'd2, 8'd2, 32'd0, 1, 100);
    check("t6_nrec", rd.size(), 64'd1);
    if (rd.size() == 1) begin
      check("t6_total", {32'd0, rt[0]}, 64'd0);
      check("t6_sat", {63'd0, rs[0]}, 64'd0);
      check("t6_match", {32'd0, rm[0]}, 64'd70);
    end
`ifdef AUTOCORR_ALARM_EN
    check("t6_alarm", {63'd0, o_alarm}, 64'd1);
    for (int c = 0; c < 5; c++) step();
    check("t6_alarm_sticky", {63'd0, o_alarm}, 64'd1);
    match_val = 32'd50;
    sweep(8'd2, 8'd2, 32'd3, 1, 100);
    check("t6_alarm_clr", {63'd0, o_alarm}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
